// File: rtl/sr_cmd_conditioner.sv
// Conditions two raw asynchronous commands (set/clear) into clean S/R/en drive
// bursts for an SR latch: synchronize, debounce, edge-detect, arbitrate, queue.
module sr_cmd_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PULSE_CYCLES    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic set_raw,
  input  logic clr_raw,
  output logic S,
  output logic R,
  output logic en,
  output logic busy,
  output logic conflict,
  output logic overrun
);

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] PC_LAST = 4'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DRIVE_SET = 2'd1,
    DRIVE_CLR = 2'd2,
    GAP       = 2'd3
  } state_t;

  // Channel index 0 = set, 1 = clear.
  logic [1:0] raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] stable;
  logic [1:0] stable_d;
  logic [1:0] arm;
  logic [1:0] req;
  logic [1:0] warm;
  logic [7:0] db_cnt [2];

  logic set_req;
  logic clr_req;

  state_t     state;
  state_t     state_n;
  logic [3:0] pcnt;
  logic [3:0] pcnt_n;
  logic       pend_vld;
  logic       pend_vld_n;
  logic       pend_set;
  logic       pend_set_n;
  logic       conflict_n;
  logic       overrun_n;

  assign raw     = {clr_raw, set_raw};
  assign set_req = req[0];
  assign clr_req = req[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      warm  <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      warm  <= {warm[0], 1'b1};
    end
  end

  // A channel is armed only once its synchronized input has been seen low
  // after reset, so a level held across reset release never fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable   <= '0;
      stable_d <= '0;
      arm      <= '0;
      req      <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        stable_d[i] <= stable[i];
        req[i]      <= arm[i] & stable[i] & ~stable_d[i];
        if (warm[1] && !sync2[i]) begin
          arm[i] <= 1'b1;
        end
        if (sync2[i] != stable[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            stable[i] <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 8'd1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    state_n    = state;
    pcnt_n     = pcnt;
    pend_vld_n = pend_vld;
    pend_set_n = pend_set;
    conflict_n = 1'b0;
    overrun_n  = 1'b0;

    unique case (state)
      IDLE: begin
        if (set_req && clr_req) begin
          conflict_n = 1'b1;
        end else if (set_req || clr_req) begin
          state_n    = set_req ? DRIVE_SET : DRIVE_CLR;
          pcnt_n     = '0;
          overrun_n  = pend_vld;
          pend_vld_n = 1'b0;
        end else if (pend_vld) begin
          state_n    = pend_set ? DRIVE_SET : DRIVE_CLR;
          pcnt_n     = '0;
          pend_vld_n = 1'b0;
        end
      end
      DRIVE_SET, DRIVE_CLR: begin
        if (pcnt == PC_LAST) begin
          state_n = GAP;
        end else begin
          pcnt_n = pcnt + 4'd1;
        end
      end
      GAP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (state != IDLE) begin
      if (set_req && clr_req) begin
        conflict_n = 1'b1;
      end else if (set_req || clr_req) begin
        pend_vld_n = 1'b1;
        pend_set_n = set_req;
        overrun_n  = pend_vld;
      end
    end
  end

  // Outputs are registered from the next state so they always agree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pcnt     <= '0;
      pend_vld <= 1'b0;
      pend_set <= 1'b0;
      S        <= 1'b0;
      R        <= 1'b0;
      en       <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_n;
      pcnt     <= pcnt_n;
      pend_vld <= pend_vld_n;
      pend_set <= pend_set_n;
      S        <= (state_n == DRIVE_SET);
      R        <= (state_n == DRIVE_CLR);
      en       <= (state_n == DRIVE_SET) || (state_n == DRIVE_CLR);
      busy     <= (state_n != IDLE);
      conflict <= conflict_n;
      overrun  <= overrun_n;
    end
  end

  a_no_sr: assert property (@(posedge clk) disable iff (rst) !(S && R));
  a_en:    assert property (@(posedge clk) disable iff (rst) en == (S | R));

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Directed bench for sr_cmd_conditioner: per-edge traces against hand-built
// expectation masks (bit j = expected value just after clock edge j).
module tb_sr_cmd_conditioner;

  logic clk;
  logic rst;
  logic set_raw;
  logic clr_raw;

  logic s_a, r_a, en_a, busy_a, conf_a, ovr_a;
  logic s_b, r_b, en_b, busy_b, conf_b, ovr_b;

  int unsigned n_chk;
  int unsigned n_pass;

  localparam logic [63:0] ONES = '1;

  sr_cmd_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES(2)
  ) u_dut (
    .clk(clk), .rst(rst), .set_raw(set_raw), .clr_raw(clr_raw),
    .S(s_a), .R(r_a), .en(en_a), .busy(busy_a),
    .conflict(conf_a), .overrun(ovr_a)
  );

  // Fast-debounce, long-pulse instance: widens the burst window so two
  // distinct requests can land inside a single burst.
  sr_cmd_conditioner #(
    .DEBOUNCE_CYCLES(1),
    .PULSE_CYCLES(4)
  ) u_fast (
    .clk(clk), .rst(rst), .set_raw(set_raw), .clr_raw(clr_raw),
    .S(s_b), .R(r_b), .en(en_b), .busy(busy_b),
    .conflict(conf_b), .overrun(ovr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic release_rst();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic set_lvl);
    @(posedge clk);
    #3;
    rst     = 1'b1;
    set_raw = set_lvl;
    clr_raw = 1'b0;
    release_rst();
  endtask

  // sp/cp bit j = raw level driven after edge j; expectations indexed by edge.
  task automatic run_scn(input string tag, input logic sel, input int unsigned n,
                         input logic [63:0] sp, input logic [63:0] cp,
                         input logic [63:0] es, input logic [63:0] er,
                         input logic [63:0] eb, input logic [63:0] ec,
                         input logic [63:0] eo);
    logic [5:0] obs;
    logic [5:0] expv;
    for (int unsigned j = 0; j < n; j++) begin
      set_raw = sp[j];
      clr_raw = cp[j];
      @(posedge clk);
      #1;
      obs  = sel ? {s_b, r_b, en_b, busy_b, conf_b, ovr_b}
                 : {s_a, r_a, en_a, busy_a, conf_a, ovr_a};
      expv = {es[j+1], er[j+1], es[j+1] | er[j+1], eb[j+1], ec[j+1], eo[j+1]};
      check($sformatf("%s e%0d {S,R,en,busy,conf,ovr}", tag, j + 1), 32'(obs), 32'(expv));
      check($sformatf("%s e%0d S&R", tag, j + 1), 32'({s_a & r_a, s_b & r_b}), 32'd0);
    end
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    rst     = 1'b0;
    set_raw = 1'b0;
    clr_raw = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("reset_state", 32'({s_a, r_a, en_a, busy_a, conf_a, ovr_a,
                              s_b, r_b, en_b, busy_b, conf_b, ovr_b}), 32'd0);
    release_rst();

    // Async reset mid-burst, then raw held high across release: no burst.
    run_scn("rst_pre", 1'b0, 8, ONES, '0, 64'h100, '0, 64'h100, '0, '0);
    #3 rst = 1'b1;
    #1;
    check("rst_async", 32'({s_a, r_a, en_a, busy_a, conf_a, ovr_a,
                            s_b, r_b, en_b, busy_b, conf_b, ovr_b}), 32'd0);
    release_rst();
    run_scn("rst_hold", 1'b0, 20, ONES, '0, '0, '0, '0, '0, '0);
    run_scn("rst_hold_fast", 1'b1, 10, ONES, '0, '0, '0, '0, '0, '0);

    do_reset(1'b0);
    run_scn("clean", 1'b0, 14, ONES, '0, 64'h300, '0, 64'h700, '0, '0);

    do_reset(1'b0);
    run_scn("bounce", 1'b0, 34, 64'h1FF8E31, '0, 64'h1800000, '0, 64'h3800000, '0, '0);

    do_reset(1'b0);
    run_scn("conflict", 1'b0, 16, ONES, ONES, '0, '0, '0, 64'h100, '0);

    do_reset(1'b0);
    run_scn("queue", 1'b0, 20, ONES, ~64'h1, 64'h300, 64'h3000, 64'h7700, '0, '0);

    do_reset(1'b0);
    run_scn("overrun", 1'b1, 22, ~64'hC, ~64'h1F, 64'h1E0, 64'h7800, 64'hFBE0, '0, 64'h400);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sr_cmd_conditioner.md
Name: sr_cmd_conditioner

Overview:
- Upstream stage for the team's SR latch.
- Takes two raw, asynchronous, bouncy command inputs (set and clear), then synchronizes, debounces and edge-detects them.
- Turns each accepted command into a clean, registered S/R/en drive burst for the latch.
- Guarantees S=R=1 is never driven. Simultaneous or colliding commands are flagged instead of being passed through.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive clocks a synchronized raw input must differ from its stable value before the stable value flips (legal range 1..255).
- PULSE_CYCLES, 2, clocks S or R and en are held during one drive burst (legal range 1..15).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- set_raw  input  1  raw set command, asynchronous to clk.
- clr_raw  input  1  raw clear command, asynchronous to clk.
- S  output  1  set drive to the latch, registered.
- R  output  1  reset drive to the latch, registered.
- en  output  1  latch enable, registered; high exactly while S or R is high.
- busy  output  1  high in DRIVE or GAP.
- conflict  output  1  one-clock pulse: set and clear accepted in the same cycle; neither is driven.
- overrun  output  1  one-clock pulse: a pending command was overwritten before it was issued.

Behaviour:
- Reset: asynchronous, active-high. While rst=1, all of the following are 0 immediately, independent of clk:
  - S, R, en, busy, conflict, overrun
  - both synchronizer flops, both stable levels, both debounce counters
  - the pending slot and the FSM state (IDLE)
- Reset mid-burst truncates the burst at once. After reset release, no command fires until a fresh raw rising edge passes debounce.
- Synchronizer: 2 flops per channel.
- Debounce, per channel, with an 8-bit counter:
  - If sync != stable, the counter increments; otherwise it clears to 0.
  - When the counter equals DEBOUNCE_CYCLES-1 and sync != stable, stable takes sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES clocks never changes stable.
- Request: a 0->1 change of stable produces a one-clock internal request (set_req / clr_req). A 1->0 change produces nothing.
- Latency: raw rises just before edge k and is held steady. S (or R) and en are first high after edge k+DEBOUNCE_CYCLES+3, provided the FSM is IDLE.
- FSM states:
  - IDLE: outputs low.
    - set_req only, or a pending set: go to DRIVE_SET.
    - clr_req only, or a pending clear: go to DRIVE_CLR.
    - set_req and clr_req in the same cycle: conflict=1 for that cycle, stay in IDLE, nothing driven.
    - A live request has priority over a pending one; the pending one is then dropped and overrun pulses.
  - DRIVE_SET / DRIVE_CLR:
    - S=1,en=1 (respectively R=1,en=1) for exactly PULSE_CYCLES clocks, counted by a 4-bit counter.
    - Then go to GAP.
  - GAP: one clock with S=R=en=0, then go to IDLE.
- Pending slot:
  - Holds one command (valid plus type).
  - A request arriving in DRIVE or GAP is stored in the slot.
  - A request arriving while the slot is already valid overwrites it and pulses overrun.
  - Simultaneous set_req and clr_req while not IDLE: conflict pulses, the slot is left unchanged.
  - The slot is consumed on the IDLE->DRIVE transition.
- Invariants:
  - S and R are never both 1.
  - en == S|R.
  - busy == (state != IDLE).
  - Bursts are always separated by at least 1 idle clock.

Test Plan:
- Reset: assert rst asynchronously mid-burst, between clock edges -> S, R, en, busy go to 0 immediately. Release, and keep set_raw high throughout -> no burst.
- Clean set, DEBOUNCE_CYCLES=4, PULSE_CYCLES=2: set_raw 0->1 before edge 10 and held -> S=en=1 after edges 17 and 18, GAP after edge 19, busy falls after edge 20; R stays 0.
- Bounce rejection: set_raw pulses of 1, 2 and 3 clocks, separated by lows -> no S, en or busy. A following 10-clock high -> exactly one burst.
- Conflict: set_raw and clr_raw rise together, both held -> conflict high for 1 clock, S=R=en=0 throughout.
- Queueing: clr_raw rises during a set burst, so clr_req lands in DRIVE -> S burst, GAP, then R burst of 2 clocks, with overrun staying 0.
- Overrun: during one burst, a set_req then a later clr_req -> overrun pulses once; the next burst is R (latest command wins). Throughout every scenario, check S&R never equals 1.
